enemy_scheduler: RTL and testbench
==================================

ENEMY_SCHEDULER -- requirements
Module: enemy_scheduler

Interface
REQ-001 Parameter N_SLOTS, default 2, number of enemy sprite layers scheduled.
REQ-002 Parameter SPAWN_DELAY, default 32'd50_000_000, clock cycles between successive spawns.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 e_start_qb, e_pause_qb, e_resume_qb  in  1 each  game-state commands, one-cycle pulses.
REQ-007 KO_qb  in  1  Qbert knocked out, level.
REQ-008 freeze_power  in  1  freeze power-up active, level.
REQ-009 start_pos_l, start_pos_r  in  21 each  {x[10:0],y[9:0]} of the two cubes below the pyramid top.
REQ-010 slot_end  in  N_SLOTS  per-slot end flag from each enemy layer, level.
REQ-011 e_enable  out  N_SLOTS  one-hot spawn pulse, one cycle wide.
REQ-012 e_move  out  6  jump pattern, bit k = direction of jump k+1 (0 = up-right, 1 = down-right).
REQ-013 e_XY0  out  21  spawn position; e_move and e_XY0 are valid in the e_enable cycle and held until the next spawn.
REQ-014 slot_active  out  N_SLOTS  slot currently owns a live enemy.
REQ-015 spawn_cnt  out  8  total spawns since last start, saturating at 8'hFF.

Function
REQ-016 FSM states: STOP, WAIT, PICK, ISSUE, FULL, HOLD; game sub-state: RUN, PAUSED.
REQ-017 STOP: all outputs held at reset values; e_start_qb or e_resume_qb -> WAIT with timer = 0, slot_active = 0, spawn_cnt = 0.
REQ-018 WAIT: timer increments each cycle; at timer == SPAWN_DELAY-1 -> PICK, timer cleared.
REQ-019 PICK: lowest-index slot with slot_active = 0 is selected -> ISSUE; no free slot -> FULL.
REQ-020 FULL: timer frozen; first cycle any slot is free -> PICK.
REQ-021 ISSUE: e_enable[sel] = 1 for exactly one cycle; e_move = lfsr[5:0]; e_XY0 = lfsr[6] ? start_pos_r : start_pos_l; slot_active[sel] set; spawn_cnt +1 (saturating); -> WAIT.
REQ-022 slot_active[i] cleared on the rising edge of slot_end[i] (registered previous value, one-cycle latency); a set in ISSUE wins over a simultaneous clear on the same slot.
REQ-023 LFSR 16-bit Fibonacci, taps 16,14,13,11, advances every cycle outside STOP; never reaches zero.
REQ-024 freeze_power = 1: timer frozen in WAIT, no transition out of WAIT/FULL; slot_active clearing continues.
REQ-025 KO_qb = 1 in any non-STOP state -> HOLD; HOLD issues nothing; KO_qb falling -> WAIT with timer = 0.
REQ-026 e_pause_qb in RUN -> PAUSED: FSM, timer, LFSR frozen, e_enable forced 0; e_resume_qb -> RUN, resume exactly where frozen.
REQ-027 e_start_qb while PAUSED or running -> restart as in REQ-017 (slots cleared, counters zeroed).
REQ-028 Priority when simultaneous: reset > e_start_qb > e_pause_qb > KO_qb > freeze_power > normal FSM.
REQ-029 Timer 32 bits; comparisons unsigned; SPAWN_DELAY = 0 or 1 treated as 1 (spawn attempt every cycle from WAIT).

Reset
REQ-030 On reset: state STOP, game RUN, timer 0, lfsr = LFSR_SEED, e_enable 0, e_move 0, e_XY0 0, slot_active 0, spawn_cnt 0, slot_end history 0.
REQ-031 Reset asserted mid-spawn suppresses any pending e_enable in the same cycle.

Structure
REQ-032 State enums (sched_state_t, game_sub_t) and the LFSR tap constant live in the shared game package used by all layers.
REQ-033 LFSR is one sub-module, lfsr16, with ports clk, reset, enable, seed, q[15:0].
REQ-034 Target size 150-300 lines RTL; no multipliers; no combinational paths from inputs to outputs.

Verification (SPAWN_DELAY = 8, N_SLOTS = 2)
REQ-035 reset, e_start_qb pulse at cycle 0 -> e_enable = 2'b01 pulse at cycle 10 (8 WAIT + PICK + ISSUE), spawn_cnt = 1, slot_active = 2'b01.
REQ-036 slot_end held 0 -> second spawn e_enable = 2'b10 after a further 10 cycles; third attempt stays in FULL; slot_end[0] rising -> e_enable = 2'b01 within 3 cycles.
REQ-037 e_pause_qb at timer = 4, hold 100 cycles, e_resume_qb -> spawn occurs 6 cycles after resume; e_enable never asserted while paused.
REQ-038 KO_qb high 50 cycles during WAIT -> no e_enable; after KO_qb falls next spawn 10 cycles later.
REQ-039 LFSR_SEED = 16'hACE1: first spawn e_move/e_XY0 match golden LFSR model; 65535-cycle run never reaches zero.
REQ-040 e_start_qb during FULL -> slot_active = 0, spawn_cnt = 0, next spawn on slot 0 10 cycles later.

Source files
------------

// File: rtl/enemy_scheduler_pkg.sv
// Shared game package: scheduler state encodings and LFSR constants.
package enemy_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_STOP,
        ST_WAIT,
        ST_PICK,
        ST_ISSUE,
        ST_FULL,
        ST_HOLD
    } sched_state_t;

    typedef enum logic {
        G_RUN,
        G_PAUSED
    } game_sub_t;

    // Taps 16,14,13,11 counted from the output end of a right shifter.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int XY_W   = 21;
    localparam int MOVE_W = 6;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {^(v & LFSR_TAPS), v[15:1]};
    endfunction

endpackage

// File: rtl/enemy_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR with enable; a zero seed is coerced to 1.
module lfsr16
    import enemy_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (enable) begin
            q_d = lfsr_step(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/enemy_scheduler.sv
// Spawn scheduler: paces enemy spawns into free sprite slots with
// LFSR-chosen jump patterns and start cubes.
module enemy_scheduler
    import enemy_scheduler_pkg::*;
#(
    parameter int          N_SLOTS     = 2,
    parameter logic [31:0] SPAWN_DELAY = 32'd50_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                e_start_qb,
    input  logic                e_pause_qb,
    input  logic                e_resume_qb,
    input  logic                KO_qb,
    input  logic                freeze_power,
    input  logic [XY_W-1:0]     start_pos_l,
    input  logic [XY_W-1:0]     start_pos_r,
    input  logic [N_SLOTS-1:0]  slot_end,
    output logic [N_SLOTS-1:0]  e_enable,
    output logic [MOVE_W-1:0]   e_move,
    output logic [XY_W-1:0]     e_XY0,
    output logic [N_SLOTS-1:0]  slot_active,
    output logic [7:0]          spawn_cnt
);

    // Delays of 0 and 1 both mean an attempt every cycle.
    localparam logic [31:0] DLY_M1 =
        (SPAWN_DELAY <= 32'd1) ? 32'd0 : SPAWN_DELAY - 32'd1;

    sched_state_t        state_q, state_d;
    game_sub_t           game_q, game_d;
    logic [31:0]         timer_q, timer_d;
    logic [N_SLOTS-1:0]  en_q, en_d;
    logic [MOVE_W-1:0]   move_q, move_d;
    logic [XY_W-1:0]     xy_q, xy_d;
    logic [N_SLOTS-1:0]  act_q, act_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [N_SLOTS-1:0]  end_q;

    logic [N_SLOTS-1:0]  free;
    logic [N_SLOTS-1:0]  sel_oh;
    logic [N_SLOTS-1:0]  end_rise;
    logic [15:0]         lfsr_q;
    logic                lfsr_en;

    assign free     = ~act_q;
    assign sel_oh   = free & (~free + N_SLOTS'(1));
    assign end_rise = slot_end & ~end_q;

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (lfsr_en),
        .seed   (LFSR_SEED),
        .q      (lfsr_q)
    );

    always_comb begin
        state_d = state_q;
        game_d  = game_q;
        timer_d = timer_q;
        en_d    = '0;
        move_d  = move_q;
        xy_d    = xy_q;
        cnt_d   = cnt_q;
        act_d   = act_q & ~end_rise;
        lfsr_en = 1'b0;

        if (e_start_qb) begin
            state_d = ST_WAIT;
            game_d  = G_RUN;
            timer_d = '0;
            act_d   = '0;
            cnt_d   = '0;
        end else if (state_q == ST_STOP) begin
            if (e_resume_qb) begin
                state_d = ST_WAIT;
                timer_d = '0;
                act_d   = '0;
                cnt_d   = '0;
            end
        end else if (game_q == G_PAUSED) begin
            if (e_resume_qb) begin
                game_d = G_RUN;
            end
        end else if (e_pause_qb) begin
            game_d = G_PAUSED;
        end else begin
            lfsr_en = 1'b1;
            if (KO_qb) begin
                state_d = ST_HOLD;
            end else begin
                unique case (state_q)
                    ST_WAIT: begin
                        if (!freeze_power) begin
                            if (timer_q == DLY_M1) begin
                                state_d = ST_PICK;
                                timer_d = '0;
                            end else begin
                                timer_d = timer_q + 32'd1;
                            end
                        end
                    end
                    ST_PICK: begin
                        if (|free) begin
                            state_d = ST_ISSUE;
                            en_d    = sel_oh;
                            move_d  = lfsr_q[MOVE_W-1:0];
                            xy_d    = lfsr_q[6] ? start_pos_r
                                                : start_pos_l;
                            // A new spawn beats a same-cycle end.
                            act_d   = act_d | sel_oh;
                            cnt_d   = (cnt_q == 8'hFF) ? cnt_q
                                                       : cnt_q + 8'd1;
                        end else begin
                            state_d = ST_FULL;
                        end
                    end
                    ST_ISSUE: state_d = ST_WAIT;
                    ST_FULL: begin
                        if (!freeze_power && (|free)) begin
                            state_d = ST_PICK;
                        end
                    end
                    ST_HOLD: begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STOP;
            game_q  <= G_RUN;
            timer_q <= '0;
            en_q    <= '0;
            move_q  <= '0;
            xy_q    <= '0;
            act_q   <= '0;
            cnt_q   <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            game_q  <= game_d;
            timer_q <= timer_d;
            en_q    <= en_d;
            move_q  <= move_d;
            xy_q    <= xy_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            end_q   <= slot_end;
        end
    end

    assign e_enable    = en_q;
    assign e_move      = move_q;
    assign e_XY0       = xy_q;
    assign slot_active = act_q;
    assign spawn_cnt   = cnt_q;

endmodule

// File: tb/tb_enemy_scheduler.sv
// Directed bench for enemy_scheduler with SPAWN_DELAY = 8, two slots.
module tb_enemy_scheduler;

    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [20:0] POS_L = 21'h12345;
    localparam logic [20:0] POS_R = 21'h0ABCD;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_start_qb, e_pause_qb, e_resume_qb;
    logic        KO_qb, freeze_power;
    logic [1:0]  slot_end;
    logic [1:0]  e_enable;
    logic [5:0]  e_move;
    logic [20:0] e_XY0;
    logic [1:0]  slot_active;
    logic [7:0]  spawn_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enemy_scheduler #(
        .N_SLOTS     (2),
        .SPAWN_DELAY (32'd8),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .e_start_qb   (e_start_qb),
        .e_pause_qb   (e_pause_qb),
        .e_resume_qb  (e_resume_qb),
        .KO_qb        (KO_qb),
        .freeze_power (freeze_power),
        .start_pos_l  (POS_L),
        .start_pos_r  (POS_R),
        .slot_end     (slot_end),
        .e_enable     (e_enable),
        .e_move       (e_move),
        .e_XY0        (e_XY0),
        .slot_active  (slot_active),
        .spawn_cnt    (spawn_cnt)
    );

    // Golden LFSR: right shift, feedback from taps 16,14,13,11.
    function automatic logic [15:0] mstep(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [15:0] madv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = mstep(r);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input int maxc, inout int n);
        while (e_enable == 2'b00 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_start();
        e_start_qb = 1'b1;
        tick();
        e_start_qb = 1'b0;
    endtask

    task automatic test_reset();
        int hits;
        reset = 1'b1;
        e_start_qb = 0; e_pause_qb = 0; e_resume_qb = 0;
        KO_qb = 0; freeze_power = 0; slot_end = 2'b00;
        repeat (3) tick();
        checks++;
        if (e_enable !== 2'b00) begin
            errors++; $display("FAIL rst_en got %b exp 00", e_enable);
        end
        checks++;
        if (e_move !== 6'd0) begin
            errors++; $display("FAIL rst_move got %h exp 0", e_move);
        end
        checks++;
        if (e_XY0 !== 21'd0) begin
            errors++; $display("FAIL rst_xy got %h exp 0", e_XY0);
        end
        checks++;
        if (slot_active !== 2'b00 || spawn_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_slots got %b/%0d exp 00/0",
                     slot_active, spawn_cnt);
        end
        reset = 1'b0;
        hits = 0;
        repeat (20) begin
            tick();
            if (e_enable !== 2'b00) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL stop_idle got %0d pulses exp 0", hits);
        end
    endtask

    task automatic test_first_spawn();
        int n;
        logic [15:0] s;
        s = madv(SEED, 8);
        pulse_start();
        n = 1;
        wait_en(40, n);
        checks++;
        if (n != 10) begin
            errors++; $display("FAIL first_lat got %0d exp 10", n);
        end
        checks++;
        if (e_enable !== 2'b01) begin
            errors++; $display("FAIL first_en got %b exp 01", e_enable);
        end
        checks++;
        if (e_move !== s[5:0]) begin
            errors++; $display("FAIL first_move got %h exp %h", e_move, s[5:0]);
        end
        checks++;
        if (e_XY0 !== (s[6] ? POS_R : POS_L)) begin
            errors++;
            $display("FAIL first_xy got %h exp %h", e_XY0,
                     s[6] ? POS_R : POS_L);
        end
        tick();
        checks++;
        if (e_enable !== 2'b00) begin
            errors++; $display("FAIL first_width got %b exp 00", e_enable);
        end
        checks++;
        if (spawn_cnt !== 8'd1 || slot_active !== 2'b01) begin
            errors++;
            $display("FAIL first_state got %0d/%b exp 1/01",
                     spawn_cnt, slot_active);
        end
    endtask

    task automatic test_full();
        int n, hits;
        logic [15:0] s;
        s = madv(SEED, 18);
        n = 1;
        wait_en(40, n);
        checks++;
        if (n != 10 || e_enable !== 2'b10) begin
            errors++;
            $display("FAIL second_spawn got %0d/%b exp 10/10", n, e_enable);
        end
        checks++;
        if (e_move !== s[5:0]) begin
            errors++; $display("FAIL second_move got %h exp %h", e_move, s[5:0]);
        end
        tick();
        checks++;
        if (slot_active !== 2'b11 || spawn_cnt !== 8'd2) begin
            errors++;
            $display("FAIL second_state got %b/%0d exp 11/2",
                     slot_active, spawn_cnt);
        end
        hits = 0;
        repeat (30) begin
            tick();
            if (e_enable !== 2'b00) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL full_idle got %0d pulses exp 0", hits);
        end
        checks++;
        if (e_move !== s[5:0]) begin
            errors++; $display("FAIL full_hold got %h exp %h", e_move, s[5:0]);
        end
        slot_end = 2'b01;
        n = 0;
        wait_en(20, n);
        checks++;
        if (n != 3 || e_enable !== 2'b01) begin
            errors++;
            $display("FAIL refill got %0d/%b exp 3/01", n, e_enable);
        end
        slot_end = 2'b00;
        tick();
        checks++;
        if (spawn_cnt !== 8'd3 || slot_active !== 2'b11) begin
            errors++;
            $display("FAIL refill_state got %0d/%b exp 3/11",
                     spawn_cnt, slot_active);
        end
    endtask

    task automatic test_restart_full();
        int n;
        repeat (12) tick();
        pulse_start();
        checks++;
        if (slot_active !== 2'b00 || spawn_cnt !== 8'd0) begin
            errors++;
            $display("FAIL restart_clr got %b/%0d exp 00/0",
                     slot_active, spawn_cnt);
        end
        n = 1;
        wait_en(40, n);
        checks++;
        if (n != 10 || e_enable !== 2'b01) begin
            errors++;
            $display("FAIL restart_spawn got %0d/%b exp 10/01", n, e_enable);
        end
    endtask

    task automatic test_pause();
        int n, hits;
        pulse_start();
        repeat (4) tick();
        e_pause_qb = 1'b1;
        tick();
        e_pause_qb = 1'b0;
        hits = 0;
        repeat (100) begin
            tick();
            if (e_enable !== 2'b00) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL pause_quiet got %0d pulses exp 0", hits);
        end
        e_resume_qb = 1'b1;
        tick();
        e_resume_qb = 1'b0;
        n = 1;
        wait_en(40, n);
        checks++;
        if (n != 6 || e_enable !== 2'b01) begin
            errors++;
            $display("FAIL resume_lat got %0d/%b exp 6/01", n, e_enable);
        end
    endtask

    task automatic test_ko();
        int n, hits;
        pulse_start();
        repeat (2) tick();
        KO_qb = 1'b1;
        hits = 0;
        repeat (50) begin
            tick();
            if (e_enable !== 2'b00) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL ko_quiet got %0d pulses exp 0", hits);
        end
        KO_qb = 1'b0;
        n = 0;
        wait_en(40, n);
        checks++;
        if (n != 10 || e_enable !== 2'b01) begin
            errors++;
            $display("FAIL ko_release got %0d/%b exp 10/01", n, e_enable);
        end
    endtask

    task automatic test_freeze();
        int n, hits;
        pulse_start();
        tick();
        freeze_power = 1'b1;
        hits = 0;
        repeat (40) begin
            tick();
            if (e_enable !== 2'b00) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL freeze_quiet got %0d pulses exp 0", hits);
        end
        freeze_power = 1'b0;
        n = 0;
        wait_en(40, n);
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL freeze_release got %0d exp 8", n);
        end
    endtask

    task automatic test_lfsr_period();
        int zeros;
        logic [15:0] v0;
        pulse_start();
        freeze_power = 1'b1;
        tick();
        v0 = dut.u_lfsr.q;
        zeros = 0;
        repeat (65535) begin
            tick();
            if (dut.u_lfsr.q == 16'h0000) zeros++;
        end
        checks++;
        if (zeros != 0) begin
            errors++; $display("FAIL lfsr_zero got %0d hits exp 0", zeros);
        end
        checks++;
        if (dut.u_lfsr.q !== v0) begin
            errors++;
            $display("FAIL lfsr_period got %h exp %h", dut.u_lfsr.q, v0);
        end
        freeze_power = 1'b0;
    endtask

    task automatic test_priority();
        int n, hits;
        e_start_qb = 1'b1;
        e_pause_qb = 1'b1;
        tick();
        e_start_qb = 1'b0;
        e_pause_qb = 1'b0;
        n = 1;
        wait_en(40, n);
        checks++;
        if (n != 10) begin
            errors++; $display("FAIL start_over_pause got %0d exp 10", n);
        end
        pulse_start();
        repeat (8) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (e_enable !== 2'b00 || spawn_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid got %b/%0d exp 00/0", e_enable, spawn_cnt);
        end
        checks++;
        if (e_move !== 6'd0 || slot_active !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_out got %h/%b exp 0/00",
                     e_move, slot_active);
        end
        reset = 1'b0;
        hits = 0;
        repeat (20) begin
            tick();
            if (e_enable !== 2'b00) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL post_reset_idle got %0d exp 0", hits);
        end
        e_resume_qb = 1'b1;
        tick();
        e_resume_qb = 1'b0;
        n = 1;
        wait_en(40, n);
        checks++;
        if (n != 10 || e_enable !== 2'b01) begin
            errors++;
            $display("FAIL resume_from_stop got %0d/%b exp 10/01", n, e_enable);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_full();
        test_restart_full();
        test_pause();
        test_ko();
        test_freeze();
        test_lfsr_period();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
